sensor_event_queue: RTL and testbench

- Sits between the sensor front-ends (gyro, touch, sonic, joystick) and screen_top.
- Synchronizes and debounces the eight level/strobe sensor outputs and detects their rising edges.
- Arbitrates simultaneous edges by fixed priority and queues them as 4-bit event codes.
- Delivers the codes to the screen stage over a valid/ready handshake, so no sensor event is lost while the screen is busy redrawing.

---
 rtl/sensor_event_queue_if.sv | 28 ++
 rtl/sensor_event_queue.sv | 126 ++++++++++++
 tb/tb_sensor_event_queue.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_event_queue_if.sv
// Sensor levels, control pulse and event handshake between the sensor
// front-ends, sensor_event_queue (slave) and the screen stage.
interface sensor_event_queue_if;
    logic       go;
    logic       awaking;
    logic       touched;
    logic       expecting;
    logic       pressed;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       evt_ready;
    logic       overflow;
    logic       armed;

    modport master (
        output go, awaking, touched, expecting, pressed, up, down, left, right, evt_ready,
        input  evt_valid, evt_code, overflow, armed
    );

    modport slave (
        input  go, awaking, touched, expecting, pressed, up, down, left, right, evt_ready,
        output evt_valid, evt_code, overflow, armed
    );
endinterface

// File: rtl/sensor_event_queue.sv
// Synchronizes and debounces eight sensor lines, turns their rising edges into
// prioritized 4-bit event codes and queues them for the screen stage.
module sensor_event_queue #(
    parameter int DEB_CYCLES = 1000000,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sensor_event_queue_if.slave  bus
);
    localparam int N_IN  = 8;
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    // Bit i carries the input whose event code is i+1, so bit 0 has top priority.
    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync1_q, sync2_q;
    logic [N_IN-1:0] stable_q, stable_d_q;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [N_IN-1:0] rise, pend_q, pend_d, push_sel, push_mask, coalesce;
    logic [3:0]      push_code;
    logic            armed_q, overflow_q;

    logic [3:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               empty, full, pop, push;

    assign raw = {bus.right, bus.left, bus.down, bus.up,
                  bus.expecting, bus.awaking, bus.touched, bus.pressed};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
            stable_q   <= '0;
            stable_d_q <= '0;
        end else begin
            stable_d_q <= stable_q;
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]    <= '0;
                    stable_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_q & ~stable_d_q & {N_IN{armed_q}};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        push_sel  = '0;
        push_code = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_sel  = N_IN'(1) << i;
                push_code = 4'(i + 1);
            end
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign pop       = !empty && bus.evt_ready;
    assign push      = (|pend_q) && (!full || pop);
    assign push_mask = push ? push_sel : '0;
    // An edge landing on a bit that is being pushed re-arms it instead of coalescing.
    assign coalesce  = rise & pend_q & ~push_mask;
    assign pend_d    = (pend_q & ~push_mask) | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            armed_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            armed_q <= armed_q | bus.go;
            if (|coalesce)   overflow_q <= 1'b1;
            else if (bus.go) overflow_q <= 1'b0;
        end
    end

    // NOTE: FIFO storage has no reset; empty is decided by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.evt_valid = !empty;
    assign bus.evt_code  = empty ? 4'd0 : mem[rd_ptr_q];
    assign bus.overflow  = overflow_q;
    assign bus.armed     = armed_q;
endmodule

// File: tb/tb_sensor_event_queue.sv
// Bench for sensor_event_queue: directed scenarios plus random sensor activity,
// all checked every cycle against an event-level model.
`timescale 1ns/1ps
module tb_sensor_event_queue;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sensor_event_queue_if bus();

    sensor_event_queue #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sensor vector indexed by event code minus one.
    task automatic set_in(input logic [7:0] v);
        {bus.right, bus.left, bus.down, bus.up,
         bus.expecting, bus.awaking, bus.touched, bus.pressed} = v;
    endtask

    function automatic logic [7:0] get_in();
        return {bus.right, bus.left, bus.down, bus.up,
                bus.expecting, bus.awaking, bus.touched, bus.pressed};
    endfunction

    // Event-level model: per-input line history, pending flags, queue of codes.
    bit m_s1[8], m_s2[8], m_stab[8], m_rose[8], m_pend[8];
    int m_run[8];
    bit m_armed, m_ovf;
    int mq[$];

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] raw;
        bit pop, coal, ev;
        int pushed;
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0;
                m_rose[c] = 0; m_pend[c] = 0; m_run[c] = 0;
            end
            m_armed = 0;
            m_ovf   = 0;
            mq.delete();
        end else begin
            raw    = get_in();
            pop    = (mq.size() != 0) && bus.evt_ready;
            pushed = 0;
            if (mq.size() < DEPTH || pop)
                for (int c = 0; c < 8; c++)
                    if (pushed == 0 && m_pend[c]) pushed = c + 1;
            if (pop) void'(mq.pop_front());
            if (pushed != 0) mq.push_back(pushed);
            coal = 0;
            for (int c = 0; c < 8; c++) begin
                ev = m_rose[c] && m_armed;
                if (ev && m_pend[c] && pushed != c + 1) coal = 1;
                m_pend[c] = (m_pend[c] && pushed != c + 1) || ev;
            end
            if (coal) m_ovf = 1;
            else if (bus.go) m_ovf = 0;
            if (bus.go) m_armed = 1;
            for (int c = 0; c < 8; c++) begin
                m_rose[c] = 0;
                if (m_s2[c] != m_stab[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_stab[c] = m_s2[c];
                        m_run[c]  = 0;
                        m_rose[c] = m_stab[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n && chk_en) begin
            check("evt_valid", bus.evt_valid, mq.size() != 0);
            check("evt_code",  bus.evt_code,  mq.size() != 0 ? mq[0] : 0);
            check("overflow",  bus.overflow,  m_ovf);
            check("armed",     bus.armed,     m_armed);
        end
    end

    task automatic post_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int got[$];
        int exp_order[5] = '{1, 2, 3, 4, 5};
        bit seen;
        bus.go = 0;
        bus.evt_ready = 0;
        set_in(8'h00);
        #23;
        @(negedge clk);
        rst_n  = 1;
        chk_en = 1;

        // Disarmed: a held touch produces nothing.
        @(negedge clk) bus.touched = 1;
        post_edges(20);
        check("disarmed_valid", bus.evt_valid, 0);
        check("disarmed_armed", bus.armed, 0);
        @(negedge clk) bus.touched = 0;
        negs(12);

        // Armed single touch: exact latency, one-cycle visibility.
        bus.go = 1; bus.evt_ready = 1;
        @(negedge clk) bus.go = 0;
        bus.touched = 1;
        post_edges(7);
        check("lat_before_edge8", bus.evt_valid, 0);
        post_edges(1);
        check("lat_valid_edge8", bus.evt_valid, 1);
        check("lat_code_edge8", bus.evt_code, 2);
        post_edges(1);
        check("lat_valid_edge9", bus.evt_valid, 0);
        post_edges(10);
        check("held_no_repeat", bus.evt_valid, 0);
        @(negedge clk) bus.touched = 0;
        negs(10);
        bus.touched = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            post_edges(1);
            if (bus.evt_valid) seen = 1;
        end
        check("retouch_seen", seen, 1);
        check("retouch_code", bus.evt_code, 2);
        @(negedge clk) bus.touched = 0;
        negs(10);

        // Simultaneous pressed+right: priority order on consecutive cycles.
        bus.pressed = 1; bus.right = 1;
        post_edges(8);
        check("prio_first_valid", bus.evt_valid, 1);
        check("prio_first_code", bus.evt_code, 1);
        post_edges(1);
        check("prio_second_valid", bus.evt_valid, 1);
        check("prio_second_code", bus.evt_code, 8);
        post_edges(1);
        check("prio_drained", bus.evt_valid, 0);
        @(negedge clk) bus.pressed = 0; bus.right = 0;
        negs(10);

        // Fill with ready low, up stays pending, re-edge coalesces.
        bus.evt_ready = 0;
        bus.pressed = 1;   negs(8);
        bus.touched = 1;   negs(8);
        bus.awaking = 1;   negs(8);
        bus.expecting = 1; negs(8);
        bus.up = 1;        negs(10);
        check("fill_model_depth", mq.size(), DEPTH);
        check("fill_head", bus.evt_code, 1);
        check("fill_no_overflow", bus.overflow, 0);
        bus.up = 0; negs(10);
        bus.up = 1; negs(10);
        check("coalesce_overflow", bus.overflow, 1);
        bus.evt_ready = 1;
        for (int i = 0; i < 30 && got.size() < 5; i++) begin
            if (bus.evt_valid) got.push_back(int'(bus.evt_code));
            @(negedge clk);
        end
        check("drain_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            check("drain_order", i < got.size() ? got[i] : 0, exp_order[i]);
        check("drain_overflow_kept", bus.overflow, 1);
        bus.go = 1;
        @(negedge clk) bus.go = 0;
        check("go_clears_overflow", bus.overflow, 0);
        set_in(8'h00);
        negs(12);

        // Glitch shorter than the debounce window.
        bus.up = 1; negs(3);
        bus.up = 0; negs(15);
        check("glitch_no_event", bus.evt_valid, 0);

        // Asynchronous reset with two entries queued.
        bus.evt_ready = 0;
        bus.pressed = 1; bus.touched = 1;
        negs(12);
        check("prereset_valid", bus.evt_valid, 1);
        check("prereset_model_depth", mq.size(), 2);
        #1 rst_n = 0;
        #1;
        check("rst_valid", bus.evt_valid, 0);
        check("rst_code", bus.evt_code, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_armed", bus.armed, 0);
        @(negedge clk) rst_n = 1;
        negs(20);
        check("post_reset_no_stale", bus.evt_valid, 0);
        set_in(8'h00);
        negs(10);

        // Random sensor traffic with bursts of consumer back-pressure.
        bus.go = 1;
        @(negedge clk) bus.go = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [7:0] v;
            v = get_in();
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            set_in(v);
            if (((cyc / 100) % 3) == 1) bus.evt_ready = 0;
            else bus.evt_ready = ($urandom_range(0, 3) != 0);
            bus.go = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        bus.go = 0;
        set_in(8'h00);
        bus.evt_ready = 1;
        negs(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
